// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: access-size encoding and alignment helper.
package Types;

  typedef enum logic [1:0] {
    MemAccess_B = 2'b00,
    MemAccess_H = 2'b01,
    MemAccess_W = 2'b10
  } MemAccess;

  // Any encoding outside the enum behaves as a word access.
  function automatic logic is_misaligned(input MemAccess i_Access, input logic [1:0] i_AddrLo);
    case (i_Access)
      MemAccess_B: return 1'b0;
      MemAccess_H: return i_AddrLo[0];
      default:     return (i_AddrLo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module data_mem_lane_align
  import Types::*;
(
  input  MemAccess    i_Access,
  input  logic        i_Unsigned,
  input  logic [1:0]  i_AddrLo,
  input  logic [31:0] i_WrData,
  input  logic [31:0] i_RdWord,
  output logic        o_Misaligned,
  output logic [3:0]  o_ByteEn,
  output logic [31:0] o_WrWord,
  output logic [31:0] o_RdData
);

  logic [7:0]  w_Byte;
  logic [15:0] w_Half;

  always_comb begin
    o_Misaligned = is_misaligned(i_Access, i_AddrLo);
    w_Byte       = i_RdWord[{i_AddrLo, 3'b000} +: 8];
    w_Half       = i_RdWord[{i_AddrLo[1], 4'b0000} +: 16];
    o_ByteEn     = '0;
    o_WrWord     = '0;
    o_RdData     = '0;
    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (i_Access)
      MemAccess_B: begin
        o_ByteEn = 4'b0001 << i_AddrLo;
        o_WrWord = {4{i_WrData[7:0]}};
        o_RdData = {{24{~i_Unsigned & w_Byte[7]}}, w_Byte};
      end
      MemAccess_H: begin
        o_ByteEn = i_AddrLo[1] ? 4'b1100 : 4'b0011;
        o_WrWord = {2{i_WrData[15:0]}};
        o_RdData = {{16{~i_Unsigned & w_Half[15]}}, w_Half};
      end
      default: begin
        o_ByteEn = 4'b1111;
        o_WrWord = i_WrData;
        o_RdData = i_RdWord;
      end
    endcase
    if (o_Misaligned) begin
      o_ByteEn = '0;
      o_RdData = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port word memory answering one load/store request at a time after a fixed
// number of wait states, with byte/half/word lanes and alignment checking.
module data_mem_responder
  import Types::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Req,
  input  logic                  i_WrEnable,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  MemAccess              i_Access,
  input  logic                  i_Unsigned,
  input  logic [31:0]           i_WrData,
  output logic                  o_Ack,
  output logic [31:0]           o_RdData,
  output logic                  o_Misaligned,
  output logic                  o_Busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                r_State;
  logic [3:0]            r_Count;
  logic                  r_WrEnable;
  logic [ADDR_WIDTH-1:0] r_Addr;
  MemAccess              r_Access;
  logic                  r_Unsigned;
  logic [31:0]           r_WrData;
  logic                  r_Ack;
  logic [31:0]           r_RdData;
  logic                  r_Misaligned;
  logic [31:0]           r_Mem [DEPTH];

  logic                  w_Accept;
  logic                  w_EnterResp;
  logic                  w_UseIn;
  logic                  w_CurWr;
  logic [ADDR_WIDTH-1:0] w_CurAddr;
  MemAccess              w_CurAccess;
  logic                  w_CurUnsigned;
  logic [31:0]           w_CurWrData;
  logic [IDX_W-1:0]      w_Index;
  logic [31:0]           w_RdWord;
  logic                  w_Misaligned;
  logic [3:0]            w_ByteEn;
  logic [31:0]           w_WrWord;
  logic [31:0]           w_LoadData;
  logic                  w_MemWrite;

  // With zero wait states the array is touched on the accept edge itself, so the
  // datapath looks at the live inputs in IDLE and at the latched copy afterwards.
  always_comb begin
    w_Accept      = (r_State == IDLE) && i_Req;
    w_EnterResp   = (w_Accept && (WAIT_STATES == 0)) ||
                    ((r_State == WAIT) && (r_Count <= 4'd1));
    w_UseIn       = (r_State == IDLE);
    w_CurWr       = w_UseIn ? i_WrEnable : r_WrEnable;
    w_CurAddr     = w_UseIn ? i_Addr     : r_Addr;
    w_CurAccess   = w_UseIn ? i_Access   : r_Access;
    w_CurUnsigned = w_UseIn ? i_Unsigned : r_Unsigned;
    w_CurWrData   = w_UseIn ? i_WrData   : r_WrData;
    w_Index       = IDX_W'(32'(w_CurAddr[ADDR_WIDTH-1:2]) % DEPTH);
    w_RdWord      = r_Mem[w_Index];
    w_MemWrite    = w_EnterResp && w_CurWr && !i_Reset;
  end

  data_mem_lane_align u_lane_align (
    .i_Access     (w_CurAccess),
    .i_Unsigned   (w_CurUnsigned),
    .i_AddrLo     (w_CurAddr[1:0]),
    .i_WrData     (w_CurWrData),
    .i_RdWord     (w_RdWord),
    .o_Misaligned (w_Misaligned),
    .o_ByteEn     (w_ByteEn),
    .o_WrWord     (w_WrWord),
    .o_RdData     (w_LoadData)
  );

  // Array contents survive reset; only the handshake state is cleared.
  always_ff @(posedge i_Clock) begin
    if (w_MemWrite) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_ByteEn[b]) r_Mem[w_Index][8*b +: 8] <= w_WrWord[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State      <= IDLE;
      r_Count      <= '0;
      r_WrEnable   <= 1'b0;
      r_Addr       <= '0;
      r_Access     <= MemAccess_B;
      r_Unsigned   <= 1'b0;
      r_WrData     <= '0;
      r_Ack        <= 1'b0;
      r_RdData     <= '0;
      r_Misaligned <= 1'b0;
    end else begin
      r_Ack        <= w_EnterResp;
      r_Misaligned <= w_EnterResp && w_Misaligned;
      r_RdData     <= (w_EnterResp && !w_CurWr) ? w_LoadData : '0;
      case (r_State)
        IDLE: begin
          if (i_Req) begin
            r_WrEnable <= i_WrEnable;
            r_Addr     <= i_Addr;
            r_Access   <= i_Access;
            r_Unsigned <= i_Unsigned;
            r_WrData   <= i_WrData;
            if (WAIT_STATES == 0) begin
              r_State <= RESP;
            end else begin
              r_State <= WAIT;
              r_Count <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (w_EnterResp) begin
            r_State <= RESP;
            r_Count <= '0;
          end else begin
            r_Count <= r_Count - 4'd1;
          end
        end
        RESP:    r_State <= IDLE;
        default: r_State <= IDLE;
      endcase
    end
  end

  assign o_Ack        = r_Ack;
  assign o_RdData     = r_RdData;
  assign o_Misaligned = r_Misaligned;
  assign o_Busy       = (r_State != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed reference memory,
// with two instances: two wait states at full depth, and zero wait states with a small wrapping array.
module tb_data_mem_responder;
  import Types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_Req, a_We, a_Uns, a_Ack, a_Mis, a_Busy;
  logic [11:0] a_Addr;
  MemAccess    a_Acc;
  logic [31:0] a_WData, a_Rd;
  logic        b_Req, b_We, b_Uns, b_Ack, b_Mis, b_Busy;
  logic [11:0] b_Addr;
  MemAccess    b_Acc;
  logic [31:0] b_WData, b_Rd;

  data_mem_responder #(.ADDR_WIDTH(12), .DEPTH(1024), .WAIT_STATES(2)) u_dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Req(a_Req), .i_WrEnable(a_We), .i_Addr(a_Addr),
    .i_Access(a_Acc), .i_Unsigned(a_Uns), .i_WrData(a_WData), .o_Ack(a_Ack),
    .o_RdData(a_Rd), .o_Misaligned(a_Mis), .o_Busy(a_Busy));

  data_mem_responder #(.ADDR_WIDTH(12), .DEPTH(256), .WAIT_STATES(0)) u_dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Req(b_Req), .i_WrEnable(b_We), .i_Addr(b_Addr),
    .i_Access(b_Acc), .i_Unsigned(b_Uns), .i_WrData(b_WData), .o_Ack(b_Ack),
    .o_RdData(b_Rd), .o_Misaligned(b_Mis), .o_Busy(b_Busy));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mm [2][4096];
  logic [31:0] last_rd;
  logic        last_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic        get_ack(input int sel);  return sel != 0 ? b_Ack  : a_Ack;  endfunction
  function automatic logic        get_mis(input int sel);  return sel != 0 ? b_Mis  : a_Mis;  endfunction
  function automatic logic        get_busy(input int sel); return sel != 0 ? b_Busy : a_Busy; endfunction
  function automatic logic [31:0] get_rd(input int sel);   return sel != 0 ? b_Rd   : a_Rd;   endfunction

  task automatic drive(input int sel, input logic req, input logic we, input logic [11:0] addr,
                       input logic [1:0] acc, input logic uns, input logic [31:0] wd);
    if (sel != 0) begin
      b_Req = req; b_We = we; b_Addr = addr; b_Acc = MemAccess'(acc); b_Uns = uns; b_WData = wd;
    end else begin
      a_Req = req; a_We = we; a_Addr = addr; a_Acc = MemAccess'(acc); a_Uns = uns; a_WData = wd;
    end
  endtask

  task automatic set_req(input int sel, input logic req);
    if (sel != 0) b_Req = req; else a_Req = req;
  endtask

  // Reference: memory as a flat byte array; word index wraps modulo the instance depth.
  function automatic int unsigned phys(input int sel, input logic [11:0] addr, input int unsigned k);
    int unsigned dep = (sel != 0) ? 256 : 1024;
    return ((int'(addr) >> 2) % dep) * 4 + (int'(addr) & 3) + k;
  endfunction

  function automatic void model(input int sel, input logic we, input logic [11:0] addr,
                                input logic [1:0] acc, input logic uns, input logic [31:0] wd,
                                output logic [31:0] rd, output logic mis);
    int unsigned sz = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
    logic [31:0] v = '0;
    mis = (int'(addr) % sz) != 0;
    rd  = '0;
    if (!mis) begin
      for (int unsigned k = 0; k < sz; k++) begin
        if (we) mm[sel][phys(sel, addr, k)] = wd[8*k +: 8];
        else    v = v | (32'(mm[sel][phys(sel, addr, k)]) << (8*k));
      end
      if (!we) begin
        if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  task automatic do_access(input int sel, input logic we, input logic [11:0] addr,
                           input logic [1:0] acc, input logic uns, input logic [31:0] wd,
                           input string tag);
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          n;
    int          ws = (sel != 0) ? 0 : 2;
    model(sel, we, addr, acc, uns, wd, exp_rd, exp_mis);
    @(negedge clk);
    drive(sel, 1'b1, we, addr, acc, uns, wd);
    @(posedge clk); #1;
    set_req(sel, 1'b0);
    n = 1;
    if (ws > 0) chk({tag, "/busy"}, 32'(get_busy(sel)), 32'd1);
    while (!get_ack(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/lat"}, 32'(n), 32'(ws + 1));
    last_rd  = get_rd(sel);
    last_mis = get_mis(sel);
    chk({tag, "/rd"}, last_rd, exp_rd);
    chk({tag, "/mis"}, 32'(last_mis), 32'(exp_mis));
    @(posedge clk); #1;
    chk({tag, "/ackoff"}, {29'd0, get_ack(sel), get_mis(sel), get_busy(sel)}, 32'd0);
    chk({tag, "/rdoff"}, get_rd(sel), 32'd0);
  endtask

  task automatic held(input int sel, input int period, input int nedges, input string tag);
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          acks = 0;
    int          last = -1;
    int          n = 0;
    model(sel, 1'b0, 12'h010, 2'd2, 1'b0, 32'd0, exp_rd, exp_mis);
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'd0);
    for (int e = 1; e <= nedges; e++) begin
      @(posedge clk); #1;
      if (get_ack(sel)) begin
        acks++;
        chk({tag, "/rd"}, get_rd(sel), exp_rd);
        if (last >= 0) chk({tag, "/gap"}, 32'(e - last), 32'(period));
        last = e;
      end
    end
    chk({tag, "/acks"}, 32'(acks), 32'(nedges / period));
    @(negedge clk);
    set_req(sel, 1'b0);
    while (get_busy(sel) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/drain"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic rand_access(input int sel, input logic [11:0] addr, input string tag);
    logic [1:0] acc = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    do_access(sel, 1'($urandom), addr, acc, 1'($urandom), $urandom, tag);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {a_Rd[30:0], a_Ack}, 32'd0);
    chk("rst_a_flags", {30'd0, a_Mis, a_Busy}, 32'd0);
    chk("rst_b", {b_Rd[30:0], b_Ack}, 32'd0);
    chk("rst_b_flags", {30'd0, b_Mis, b_Busy}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int w = 0; w < 32; w++) do_access(0, 1'b1, 12'(w * 4), 2'd2, 1'b0, $urandom, "init_a");
    for (int w = 0; w < 16; w++) do_access(1, 1'b1, 12'(w * 4), 2'd2, 1'b0, $urandom, "init_b");

    do_access(0, 1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, "sw10");
    do_access(0, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, "lw10");
    chk("lw10_k", last_rd, 32'hDEADBEEF);
    do_access(0, 1'b1, 12'h013, 2'd0, 1'b0, 32'h000000A5, "sb13");
    do_access(0, 1'b0, 12'h013, 2'd0, 1'b0, 32'h0, "lb13");
    chk("lb13_k", last_rd, 32'hFFFFFFA5);
    do_access(0, 1'b0, 12'h013, 2'd0, 1'b1, 32'h0, "lbu13");
    chk("lbu13_k", last_rd, 32'h000000A5);
    do_access(0, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, "lw10b");
    chk("lw10b_k", last_rd, 32'hA5ADBEEF);
    do_access(0, 1'b1, 12'h012, 2'd1, 1'b0, 32'h00001234, "sh12");
    do_access(0, 1'b0, 12'h012, 2'd1, 1'b0, 32'h0, "lh12");
    chk("lh12_k", last_rd, 32'h00001234);
    do_access(0, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0, "lw10c");
    chk("lw10c_k", last_rd, 32'h1234BEEF);
    do_access(0, 1'b0, 12'h011, 2'd2, 1'b0, 32'h0, "lw11");
    chk("lw11_k", {last_rd[30:0], ~last_mis}, 32'd0);
    do_access(0, 1'b1, 12'h016, 2'd2, 1'b0, 32'hCAFEF00D, "sw16");
    chk("sw16_k", 32'(last_mis), 32'd1);
    do_access(0, 1'b0, 12'h014, 2'd2, 1'b0, 32'h0, "lw14");
    do_access(0, 1'b0, 12'h010, 2'd3, 1'b0, 32'h0, "lx10");
    chk("lx10_k", last_rd, 32'h1234BEEF);

    do_access(0, 1'b1, 12'h020, 2'd2, 1'b0, 32'h11223344, "sw20");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 12'h020, 2'd2, 1'b0, 32'h55AA55AA);
    @(posedge clk); #1;
    set_req(0, 1'b0);
    chk("abort_busy_pre", 32'(a_Busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(a_Busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_noack", {30'd0, a_Ack, a_Busy}, 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    do_access(0, 1'b0, 12'h020, 2'd2, 1'b0, 32'h0, "lw20");
    chk("lw20_k", last_rd, 32'h11223344);

    held(0, 4, 16, "held_a");
    held(1, 2, 16, "held_b");

    for (int i = 0; i < 300; i++)
      rand_access(0, 12'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)), "rnd_a");
    for (int i = 0; i < 200; i++)
      rand_access(1, 12'(($urandom_range(0, 3) * 256 + $urandom_range(0, 15)) * 4
                         + $urandom_range(0, 3)), "rnd_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
